ysyx_23060191_ifu: RTL and testbench

YSYX_23060191_IFU -- requirements
Module: ysyx_23060191_ifu

---
 rtl/ysyx_23060191_ifu_if.sv | 26 ++
 rtl/ysyx_23060191_ifu.sv | 73 +++++++
 tb/tb_ysyx_23060191_ifu.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ysyx_23060191_ifu_if.sv
// ysyx_23060191_ifu_if: instruction-memory, redirect and decoder handshakes of the fetch unit.
interface ysyx_23060191_ifu_if #(
    parameter int CPU_WIDTH = 32
);
    logic                 imem_req_valid;
    logic                 imem_req_ready;
    logic [CPU_WIDTH-1:0] imem_req_addr;
    logic                 imem_rsp_valid;
    logic [CPU_WIDTH-1:0] imem_rsp_data;
    logic                 redirect_valid;
    logic [CPU_WIDTH-1:0] redirect_pc;
    logic                 inst_valid;
    logic                 inst_ready;
    logic [CPU_WIDTH-1:0] inst;
    logic [CPU_WIDTH-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/ysyx_23060191_ifu.sv
// ysyx_23060191_ifu: single-outstanding instruction fetch FSM with redirect squash and stale-response drop.
module ysyx_23060191_ifu #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    ysyx_23060191_ifu_if.master bus
);
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;
    localparam logic [CPU_WIDTH-1:0] ALIGN = {{(CPU_WIDTH-2){1'b1}}, 2'b00};

    logic [1:0]           state, state_n;
    logic [CPU_WIDTH-1:0] pc, pc_n, inst_q, inst_pc_q;
    logic                 load;
    logic                 redir, rsp;
    logic [CPU_WIDTH-1:0] rpc;

    assign redir = bus.redirect_valid;
    assign rsp   = bus.imem_rsp_valid;
    assign rpc   = bus.redirect_pc & ALIGN;

    assign bus.imem_req_valid = rst_n && state == S_REQ;
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = rst_n && state == S_HOLD && !redir;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;

    // A redirect always wins; it only decides whether an in-flight response must still be drained.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        load    = 1'b0;
        case (state)
            S_REQ: begin
                pc_n    = redir ? rpc : pc;
                state_n = bus.imem_req_ready ? (redir ? S_DROP : S_WAIT) : S_REQ;
            end
            S_WAIT: begin
                pc_n    = redir ? rpc : pc;
                load    = rsp && !redir;
                state_n = redir ? (rsp ? S_REQ : S_DROP) : (rsp ? S_HOLD : S_WAIT);
            end
            S_HOLD: begin
                pc_n    = redir ? rpc : (bus.inst_ready ? pc + CPU_WIDTH'(4) : pc);
                state_n = (redir || bus.inst_ready) ? S_REQ : S_HOLD;
            end
            default: begin
                pc_n    = redir ? rpc : pc;
                state_n = rsp ? S_REQ : S_DROP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_REQ;
            pc        <= RESET_PC & ALIGN;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (load) begin
                inst_q    <= bus.imem_rsp_data;
                inst_pc_q <= pc;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_23060191_ifu.sv
// tb_ysyx_23060191_ifu: directed vector table plus a zero-wait throughput sequence for the fetch unit.
module tb_ysyx_23060191_ifu;
    localparam logic [31:0] A = 32'h8000_0000;

    typedef struct {
        logic        rst_n, rdy, rsp;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        ir;
        logic        erv;
        logic [31:0] eaddr;
        logic        eiv, ci;
        logic [31:0] einst, eipc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t tv[$];

    ysyx_23060191_ifu_if #(.CPU_WIDTH(32)) bus ();

    ysyx_23060191_ifu #(.CPU_WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic rdy, input logic rsp, input logic [31:0] rdata,
                                input logic redir, input logic [31:0] rpc, input logic ir,
                                input logic erv, input logic [31:0] eaddr, input logic eiv,
                                input logic ci, input logic [31:0] einst, input logic [31:0] eipc);
        vec_t v;
        v = '{r, rdy, rsp, rdata, redir, rpc, ir, erv, eaddr, eiv, ci, einst, eipc};
        return v;
    endfunction

    task automatic drive(input logic r, input logic rdy, input logic rsp, input logic [31:0] rdata,
                         input logic redir, input logic [31:0] rpc, input logic ir);
        rst_n              = r;
        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rdata;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.inst_ready     = ir;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   first, n;
        logic prev;
        logic [31:0] last_addr;
        // reset, basic fetch, 5-cycle decoder stall
        tv.push_back(mk(0,0,0,0,0,0,0, 0,A,0,1,0,0));
        tv.push_back(mk(1,1,0,0,0,0,0, 1,A,0,0,0,0));
        tv.push_back(mk(1,0,1,32'h0010_0093,0,0,0, 0,A,0,0,0,0));
        tv.push_back(mk(1,0,0,0,0,0,1, 0,A,1,1,32'h0010_0093,A));
        tv.push_back(mk(1,1,0,0,0,0,0, 1,A+4,0,0,0,0));
        tv.push_back(mk(1,0,1,32'h0020_0113,0,0,0, 0,A+4,0,0,0,0));
        for (int i = 0; i < 5; i++) tv.push_back(mk(1,0,0,0,0,0,0, 0,A+4,1,1,32'h0020_0113,A+4));
        tv.push_back(mk(1,0,0,0,0,0,1, 0,A+4,1,1,32'h0020_0113,A+4));
        tv.push_back(mk(1,0,0,0,0,0,0, 1,A+8,0,0,0,0));
        tv.push_back(mk(1,1,0,0,0,0,0, 1,A+8,0,0,0,0));
        // redirect in WAIT, late response dropped
        tv.push_back(mk(1,0,0,0,1,32'h8000_0100,0, 0,A+8,0,0,0,0));
        tv.push_back(mk(1,0,0,0,0,0,0, 0,32'h8000_0100,0,0,0,0));
        tv.push_back(mk(1,0,1,32'hDEAD_BEEF,0,0,0, 0,32'h8000_0100,0,0,0,0));
        tv.push_back(mk(1,1,0,0,0,0,0, 1,32'h8000_0100,0,0,0,0));
        tv.push_back(mk(1,0,1,32'h0030_0193,0,0,0, 0,32'h8000_0100,0,0,0,0));
        tv.push_back(mk(1,0,0,0,0,0,0, 0,32'h8000_0100,1,1,32'h0030_0193,32'h8000_0100));
        // redirect in HOLD (misaligned target), redirect+rsp in WAIT, redirects in REQ and DROP
        tv.push_back(mk(1,0,0,0,1,32'h8000_0203,1, 0,32'h8000_0100,0,0,0,0));
        tv.push_back(mk(1,1,0,0,0,0,0, 1,32'h8000_0200,0,0,0,0));
        tv.push_back(mk(1,0,1,32'h0BAD_F00D,1,32'h8000_0300,0, 0,32'h8000_0200,0,0,0,0));
        tv.push_back(mk(1,0,0,0,1,32'h8000_0400,0, 1,32'h8000_0300,0,0,0,0));
        tv.push_back(mk(1,1,0,0,1,32'hFFFF_FFFC,0, 1,32'h8000_0400,0,0,0,0));
        tv.push_back(mk(1,0,0,0,0,0,0, 0,32'hFFFF_FFFC,0,0,0,0));
        tv.push_back(mk(1,0,1,32'h1234_5678,1,32'hFFFF_FFFF,0, 0,32'hFFFF_FFFC,0,0,0,0));
        // wrap of pc+4, response ignored in REQ
        tv.push_back(mk(1,1,0,0,0,0,0, 1,32'hFFFF_FFFC,0,0,0,0));
        tv.push_back(mk(1,0,1,32'h0040_0213,0,0,0, 0,32'hFFFF_FFFC,0,0,0,0));
        tv.push_back(mk(1,0,0,0,0,0,1, 0,32'hFFFF_FFFC,1,1,32'h0040_0213,32'hFFFF_FFFC));
        tv.push_back(mk(1,0,1,32'hCAFE_BABE,0,0,0, 1,32'h0000_0000,0,0,0,0));
        tv.push_back(mk(1,1,0,0,0,0,0, 1,32'h0000_0000,0,0,0,0));
        // reset while in WAIT
        tv.push_back(mk(0,0,1,32'h1111_1111,0,0,0, 0,32'h0000_0000,0,0,0,0));
        tv.push_back(mk(1,0,0,0,0,0,0, 1,A,0,1,0,0));
        tv.push_back(mk(1,1,0,0,0,0,0, 1,A,0,0,0,0));

        drive(0,0,0,0,0,0,0);
        step();
        step();
        foreach (tv[i]) begin
            drive(tv[i].rst_n, tv[i].rdy, tv[i].rsp, tv[i].rdata, tv[i].redir, tv[i].rpc, tv[i].ir);
            #1;
            chk($sformatf("row%0d req_valid", i), 32'(bus.imem_req_valid), 32'(tv[i].erv));
            chk($sformatf("row%0d req_addr", i), bus.imem_req_addr, tv[i].eaddr);
            chk($sformatf("row%0d inst_valid", i), 32'(bus.inst_valid), 32'(tv[i].eiv));
            if (tv[i].ci) begin
                chk($sformatf("row%0d inst", i), bus.inst, tv[i].einst);
                chk($sformatf("row%0d inst_pc", i), bus.inst_pc, tv[i].eipc);
            end
            step();
        end

        // zero-wait memory: response one cycle after acceptance, decoder always ready
        drive(0,0,0,0,0,0,0);
        step();
        step();
        first = -1;
        n = 0;
        prev = 1'b0;
        last_addr = '0;
        for (int c = 0; c < 30; c++) begin
            drive(1, 1, prev, last_addr ^ 32'h13, 0, 0, 1);
            #1;
            if (bus.inst_valid) begin
                if (first < 0) first = c;
                chk($sformatf("tp%0d inst_pc", n), bus.inst_pc, A + 32'(4 * n));
                chk($sformatf("tp%0d inst", n), bus.inst, (A + 32'(4 * n)) ^ 32'h13);
                n++;
            end
            prev = bus.imem_req_valid && bus.imem_req_ready;
            last_addr = bus.imem_req_addr;
            step();
        end
        chk("tp first inst_valid cycle", 32'(first), 32'd2);
        chk("tp inst count in 30 cycles", 32'(n), 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
